// File: rtl/mod_sequencer.sv
// Multi-cycle unsigned a mod b by repeated subtraction through the shared ALU.
// start/done handshake; the remainder and divisor registers feed the ALU operands directly.
module mod_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] OP_SUB  = 3'b110,
  parameter logic [2:0] OP_IDLE = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] div, div_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             dbz_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      div         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      rem         <= rem_nxt;
      div         <= div_nxt;
      result      <= result_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    div_nxt    = div;
    result_nxt = result;
    dbz_nxt    = div_by_zero;
    case (state)
      IDLE: if (start) begin
        rem_nxt   = a;
        div_nxt   = b;
        dbz_nxt   = 1'b0;
        state_nxt = RUN;
      end
      RUN: begin
        if (div == '0) begin
          result_nxt = rem;
          dbz_nxt    = 1'b1;
          state_nxt  = DONE;
        end else if (rem < div) begin
          result_nxt = rem;
          state_nxt  = DONE;
        end else begin
          // only reached with rem >= div, so the ALU subtraction never wraps
          rem_nxt = alu_result;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign alu_a  = rem;
  assign alu_b  = div;
  // gated by reset so the ALU sees an idle op during the reset cycle itself
  assign alu_op = (state == RUN && !reset) ? OP_SUB : OP_IDLE;

endmodule

// File: tb/tb_mod_sequencer.sv
// Bench for mod_sequencer: vector table plus scoreboard, with a behavioural ALU model
// and hand sequences for DONE-ignore and mid-run reset.
module tb_mod_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;

  always #5 clk = ~clk;

  // non-subtract ops return garbage so a wrong op code corrupts the remainder
  assign alu_result = (alu_op == 3'b110) ? alu_a - alu_b : alu_a ^ 32'hDEAD_BEEF;

  mod_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int   edges;
    int   ops;
    vec_t e;
    @(negedge clk);
    a = v.a; b = v.b; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    edges = 1;
    ops = (alu_op == 3'b110) ? 1 : 0;
    chk("alu_a_load", alu_a, v.a);
    chk("alu_b_load", alu_b, v.b);
    chk("busy_run", {31'd0, busy}, 32'd1);
    while (!done && edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (alu_op == 3'b110) ops++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.exp_res);
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.exp_dbz});
      chk("latency", edges, e.exp_lat);
      chk("sub_cycles", ops, e.exp_lat - 1);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("result_held", result, e.exp_res);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'd17,       32'd5,          32'd2,          1'b0, 5};
    vecs[1] = '{32'd3,        32'd7,          32'd3,          1'b0, 2};
    vecs[2] = '{32'd20,       32'd5,          32'd0,          1'b0, 6};
    vecs[3] = '{32'd9,        32'd0,          32'd9,          1'b1, 2};
    vecs[4] = '{32'd8,        32'd3,          32'd2,          1'b0, 4};
    vecs[5] = '{32'hFFFFFFFF, 32'h80000000,   32'h7FFFFFFF,   1'b0, 3};
    vecs[6] = '{32'd0,        32'd5,          32'd0,          1'b0, 2};
    vecs[7] = '{32'd5,        32'd5,          32'd0,          1'b0, 3};
    vecs[8] = '{32'd0,        32'd0,          32'd0,          1'b1, 2};
    vecs[9] = '{32'd1000,     32'd7,          32'd6,          1'b0, 144};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    chk("rst_alu_op_held", {29'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 10; i++) run(vecs[i]);

    // start presented while in DONE must be ignored
    @(negedge clk); a = 32'd3; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("done_seq", {31'd0, done}, 32'd1);
    chk("done_seq_res", result, 32'd3);
    a = 32'd50; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    chk("start_in_done_alu_a", alu_a, 32'd3);

    // long run, ignored mid-run start, then reset at the 10th edge
    @(negedge clk); a = 32'd100; b = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                 // edge 1
    @(posedge clk); #1;                               // edge 2
    a = 32'd5; b = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                 // edge 3
    chk("midrun_alu_b", alu_b, 32'd1);
    repeat (6) @(posedge clk);                        // edges 4..9
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    chk("pre_reset_rem", alu_a, 32'd92);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;                               // edge 10
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_alu_op", {29'd0, alu_op}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    run('{32'd5, 32'd2, 32'd1, 1'b0, 4});

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
